// File: rtl/imm_encoder.sv
// RV32I immediate encoder: scatters a 32-bit immediate into a base instruction word
// for the selected format and flags immediates that cannot be represented exactly.
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      BaseInstr,
    input  logic [2:0]       ImmSrcE,
    input  logic [31:0]      Imm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      InstrOut,
    output logic             ErrOut,
    output logic [CNT_W-1:0] ErrCount
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;

    // Handshake: a stage transfers on a rising edge when its valid and ready are both high.
    // Stage 1 moves on whenever stage 2 is empty or being drained downstream.
    logic             rdy_en;
    logic             s1_valid, s1_err, s1_adv, in_acc, in_err;
    logic [31:0]      s1_base, s1_imm;
    logic [2:0]       s1_src;
    logic             s2_valid, s2_err;
    logic [31:0]      s2_instr, merged;
    logic [CNT_W-1:0] err_cnt;
    logic signed [31:0] imm_s;

    assign imm_s   = Imm;
    assign s1_adv  = !s2_valid || OutReady;
    assign InReady = rdy_en && (!s1_valid || s1_adv);
    assign in_acc  = InValid && InReady;

    always_comb begin
        in_err = 1'b0;
        case (ImmSrcE)
            FMT_I, FMT_S: in_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FMT_B:        in_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || Imm[0];
            FMT_J:        in_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || Imm[0];
            FMT_U:        in_err = (Imm[11:0] != 12'h000);
            default:      in_err = 1'b1;
        endcase
    end

    always_comb begin
        merged = s1_base;
        case (s1_src)
            FMT_I: merged = {s1_imm[11:0], s1_base[19:0]};
            FMT_S: merged = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
            FMT_B: merged = {s1_imm[12], s1_imm[10:5], s1_base[24:12], s1_imm[4:1],
                             s1_imm[11], s1_base[6:0]};
            FMT_J: merged = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_base[11:0]};
            FMT_U: merged = {s1_imm[31:12], s1_base[11:0]};
            default: merged = s1_base;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_base  <= '0;
            s1_imm   <= '0;
            s1_src   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (in_acc) begin
                s1_valid <= 1'b1;
                s1_err   <= in_err;
                s1_base  <= BaseInstr;
                s1_imm   <= Imm;
                s1_src   <= ImmSrcE;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 only loads when it is free or its result is taken, so outputs hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_instr <= '0;
            err_cnt  <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= merged;
                    s2_err   <= s1_err;
                end
            end
            if (s2_valid && OutReady && s2_err && (err_cnt != {CNT_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign OutValid = s2_valid;
    assign InstrOut = s2_instr;
    assign ErrOut   = s2_err;
    assign ErrCount = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, backpressure, random traffic,
// counter saturation and mid-flight reset, checked through an expected queue.
module tb_imm_encoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             InValid;
    logic             InReady;
    logic [31:0]      BaseInstr;
    logic [2:0]       ImmSrcE;
    logic [31:0]      Imm;
    logic             OutValid;
    logic             OutReady;
    logic [31:0]      InstrOut;
    logic             ErrOut;
    logic [CNT_W-1:0] ErrCount;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .BaseInstr(BaseInstr), .ImmSrcE(ImmSrcE), .Imm(Imm),
        .OutValid(OutValid), .OutReady(OutReady), .InstrOut(InstrOut),
        .ErrOut(ErrOut), .ErrCount(ErrCount)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    int acc_cnt  = 0;
    int out_seen = 0;
    int exp_cnt  = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference: place immediate fields with masks and shifts
    function automatic logic [32:0] model(input logic [31:0] base, input logic [2:0] src,
                                          input logic [31:0] imm);
        logic [31:0] r;
        int s;
        logic e;
        s = imm;
        r = base;
        e = 1'b1;
        case (src)
            3'd0: begin
                r = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
                e = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                r = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                r = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                  | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 32'h1) << 7);
                e = (s < -4096) || (s > 4094) || ((imm & 32'h1) != 0);
            end
            3'd3: begin
                r = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                  | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                  | (imm & 32'h000FF000);
                e = (s < -1048576) || (s > 1048574) || ((imm & 32'h1) != 0);
            end
            3'd4: begin
                r = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
                e = (imm & 32'hFFF) != 0;
            end
            default: begin
                r = base;
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    // driver: called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] base, input logic [2:0] src, input logic [31:0] imm);
        bit done;
        done = 0;
        BaseInstr = base;
        ImmSrcE   = src;
        Imm       = imm;
        InValid   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (InReady) begin
                exp_q.push_back(model(base, src, imm));
                acc_cnt++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        InValid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard: compare each accepted output against the head of the queue
    always @(negedge clk) begin
        if (OutValid && OutReady) begin
            logic [32:0] e;
            out_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", OutValid, 0);
            end else begin
                e = exp_q.pop_front();
                check("instr", InstrOut, e[31:0]);
                check("err", ErrOut, e[32]);
                if (e[32] && exp_cnt < 255) exp_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 OutReady = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        logic [31:0] held_instr;
        logic        held_err;
        int          base_acc;
        rst_n = 1'b0;
        InValid = 1'b0;
        BaseInstr = '0;
        ImmSrcE = '0;
        Imm = '0;
        OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outvalid", OutValid, 0);
        check("rst_instr", InstrOut, 0);
        check("rst_err", ErrOut, 0);
        check("rst_errcount", ErrCount, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("inready_after_rst", InReady, 1);

        // directed formats
        send(32'h00000093, 3'b000, 32'hFFFFFFFF);
        send(32'h00202023, 3'b001, 32'hFFFFFFFC);
        send(32'h00000063, 3'b010, 32'd8);
        send(32'h00000063, 3'b010, 32'd3);
        drain();
        check("errcount_b_odd", ErrCount, 1);
        send(32'h000000EF, 3'b011, 32'h00000800);
        send(32'h00000037, 3'b100, 32'h00012345);
        send(32'h00000013, 3'b000, 32'd2048);
        send(32'h12345678, 3'b111, 32'h00000004);
        send(32'h00000013, 3'b000, 32'hFFFFF800);
        send(32'h00000063, 3'b010, 32'hFFFFF000);
        send(32'h0000006F, 3'b011, 32'h000FFFFE);
        send(32'h0000006F, 3'b011, 32'h00100000);
        drain();
        check("errcount_directed", ErrCount, exp_cnt);

        // backpressure: 5 back-to-back inputs with the output stalled
        OutReady = 1'b0;
        base_acc = acc_cnt;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(32'h00000013 + (k << 7), 3'b000, k * 100);
            end
            begin
                for (int w = 0; w < 100 && acc_cnt < base_acc + 2; w++) @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("bp_inready_low", InReady, 0);
                check("bp_outvalid", OutValid, 1);
                held_instr = InstrOut;
                held_err   = ErrOut;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_stable_instr", InstrOut, held_instr);
                    check("bp_stable_err", ErrOut, held_err);
                end
                @(posedge clk);
                #1 OutReady = 1'b1;
            end
        join
        drain();
        check("bp_count", acc_cnt - base_acc, 5);

        // random traffic with random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 4095) - 2048;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = ($urandom_range(0, 8191) - 4096) & 32'hFFFFFFFE;
            endcase
            send($urandom, 3'($urandom_range(0, 7)), imm);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 OutReady = 1'b1;
        drain();
        check("errcount_random", ErrCount, exp_cnt);

        // saturation
        for (int k = 0; k < 300; k++) send($urandom, 3'b111, $urandom);
        drain();
        check("errcount_sat", ErrCount, 255);
        check("errcount_model", ErrCount, exp_cnt);

        // reset with two items in flight
        OutReady = 1'b0;
        send(32'h00000093, 3'b000, 32'd5);
        send(32'h00000093, 3'b000, 32'd6);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_outvalid", OutValid, 0);
        check("midrst_errcount", ErrCount, 0);
        exp_q.delete();
        exp_cnt = 0;
        out_seen = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 OutReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", out_seen, 0);
        check("midrst_errcount_after", ErrCount, 0);
        send(32'h00000093, 3'b000, 32'hFFFFFFFF);
        drain();
        check("post_rst_one_out", out_seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extractor: takes a base instruction word, a format select and a 32-bit immediate, and scatters the immediate into the RISC-V RV32I bit positions for that format.
- Checks that the immediate is representable: range and alignment.
- Used by the self-test instruction generator and the boot-ROM patcher to build instructions in hardware.
- Two-stage valid/ready pipeline with full throughput and backpressure.

Parameters:
- CNT_W, 8, width of the saturating error counter ErrCount.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  input transaction valid.
- InReady  output  1  block can accept the input this cycle.
- BaseInstr  input  32  supplies opcode/rd/funct3/rs1/rs2/funct7. Bits at immediate positions for the format are ignored.
- ImmSrcE  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U. 101–111 are illegal.
- Imm  input  32  immediate, two's complement.
- OutValid  output  1  encoded result valid.
- OutReady  input  1  downstream accepts the result.
- InstrOut  output  32  encoded instruction.
- ErrOut  output  1  result is not faithfully representable.
- ErrCount  output  CNT_W  saturating count of results with ErrOut=1 that have been accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): OutValid=0, InstrOut=0, ErrOut=0, ErrCount=0, both stage valids cleared. InReady=1 from the first clk edge after rst_n deasserts. Reset mid-transaction drops all in-flight data; nothing is output afterwards for it.
- Handshake: transfer occurs on a rising edge when valid&&ready.
  - InReady = !s1_valid || s1 advancing.
  - s1 advances when !s2_valid || OutReady.
  - Outputs are held stable while OutValid&&!OutReady.
- Latency: 2 cycles from input accept to OutValid with no stall; one result per cycle sustained.
- Stage 1 registers BaseInstr, ImmSrcE and Imm, and computes the error flag.
  - I: error if Imm outside [-2048, 2047].
  - S: error if Imm outside [-2048, 2047].
  - B: error if Imm outside [-4096, 4094] or Imm[0]=1.
  - J: error if Imm outside [-1048576, 1048574] or Imm[0]=1.
  - U: error if Imm[11:0]!=0.
  - Illegal ImmSrcE: error=1.
- Stage 2 merges the immediate into the base word. Bits not listed for a format come from BaseInstr.
  - I: [31:20]=Imm[11:0].
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0].
  - B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11].
  - J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
  - U: [31:12]=Imm[31:12].
  - Illegal format: InstrOut=BaseInstr unchanged.
- On error, InstrOut is still the truncated encoding above and ErrOut=1.
- ErrCount increments by 1 on each OutValid&&OutReady&&ErrOut. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous input accept and output accept in the same cycle is legal. Pipeline occupancy is unchanged and no bubble is inserted.

Test Plan:
- I-format: BaseInstr=0x00000093, ImmSrcE=000, Imm=0xFFFFFFFF -> 2 cycles later InstrOut=0xFFF00093, ErrOut=0.
- S-format: BaseInstr=0x00202023, ImmSrcE=001, Imm=0xFFFFFFFC -> InstrOut=0xFE202E23, ErrOut=0.
- B and J formats:
  - B: BaseInstr=0x00000063, Imm=8 -> InstrOut=0x00000463.
  - B: Imm=3 -> ErrOut=1, ErrCount=1.
  - J: BaseInstr=0x000000EF, Imm=0x800 -> InstrOut=0x001000EF.
- Range and illegal-format errors:
  - U: Imm=0x00012345 -> ErrOut=1.
  - I: Imm=2048 -> ErrOut=1.
  - ImmSrcE=111 -> InstrOut=BaseInstr, ErrOut=1.
  - 300 error results with CNT_W=8 -> ErrCount stays at 255.
- Backpressure: stream 5 back-to-back inputs, hold OutReady=0 for 4 cycles.
  - InReady falls after 2 accepts.
  - Outputs stay stable while stalled.
  - After release, all 5 results arrive in order with no loss or duplication.
- Mid-operation reset: pulse rst_n low asynchronously between clock edges while 2 items are in flight.
  - OutValid=0 immediately.
  - No stale result appears after release.
  - ErrCount=0.
